// File: rtl/scoreboard_match_sequencer_pkg.sv
// Shared encodings and the win-by-margin comparator for the scoreboard game-rule controller.
package scoreboard_pkg;

  localparam int SCORE_W = 8;
  localparam int SUM_W   = SCORE_W + 1;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'b00,
    ST_LOCKOUT   = 2'b01,
    ST_GAME_OVER = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  // One extra bit so other + margin cannot wrap near the saturation value.
  function automatic logic wins(input logic [SCORE_W-1:0] mine,
                                input logic [SCORE_W-1:0] other,
                                input int points,
                                input int margin);
    logic [SUM_W-1:0] mine_w;
    logic [SUM_W-1:0] need_w;
    mine_w = {1'b0, mine};
    need_w = {1'b0, other} + SUM_W'(margin);
    return (mine_w >= SUM_W'(points)) && (mine_w >= need_w);
  endfunction

endpackage

// File: rtl/scoreboard_match_sequencer_if.sv
// Button inputs and registered score/status outputs of the game-rule controller.
interface scoreboard_match_sequencer_if;
  import scoreboard_pkg::*;

  logic               p1_button_i;
  logic               p2_button_i;
  logic               new_game_i;
  logic [SCORE_W-1:0] p1_score_o;
  logic [SCORE_W-1:0] p2_score_o;
  logic [1:0]         winner_o;
  logic [1:0]         state_o;
  logic               point_o;
  logic               conflict_o;

  modport master (
    output p1_button_i, p2_button_i, new_game_i,
    input  p1_score_o, p2_score_o, winner_o, state_o, point_o, conflict_o
  );

  modport slave (
    input  p1_button_i, p2_button_i, new_game_i,
    output p1_score_o, p2_score_o, winner_o, state_o, point_o, conflict_o
  );

endinterface

// File: rtl/scoreboard_match_sequencer_rise_detector.sv
// Previous-level flop plus rising-edge flag; the flag is combinational from the level.
module rise_detector (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/scoreboard_match_sequencer.sv
// Two-player game-rule controller: button edges to point awards, post-point lockout,
// conflict and saturation handling, win-by-margin game over.
//   state     | meaning
//   PLAY      | accepting a single-player rise as a point
//   LOCKOUT   | post-point dead time, all rises ignored
//   GAME_OVER | scores and winner frozen until a new-game rise
module scoreboard_match_sequencer
  import scoreboard_pkg::*;
#(
  parameter int WIN_POINTS     = 11,
  parameter int WIN_MARGIN     = 2,
  parameter int LOCKOUT_CYCLES = 4,
  parameter int SCORE_MAX      = 99
) (
  input  logic clk_i,
  input  logic rst_i,
  scoreboard_match_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [SCORE_W-1:0] SAT       = SCORE_W'(SCORE_MAX);
  localparam logic [CNT_W-1:0]   LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);

  state_t             state, state_nxt;
  winner_t            winner, winner_nxt;
  logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
  logic [SCORE_W-1:0] p1_score, p1_nxt, p1_inc;
  logic [SCORE_W-1:0] p2_score, p2_nxt, p2_inc;
  logic               point_q, point_nxt;
  logic               conflict_q, conflict_nxt;

  logic p1_rise, p2_rise, ng_rise;
  logic can_score, p1_award, p2_award, p1_win, p2_win;

  rise_detector u_p1_rise (.clk_i(clk_i), .rst_i(rst_i), .level(bus.p1_button_i), .rise(p1_rise));
  rise_detector u_p2_rise (.clk_i(clk_i), .rst_i(rst_i), .level(bus.p2_button_i), .rise(p2_rise));
  rise_detector u_ng_rise (.clk_i(clk_i), .rst_i(rst_i), .level(bus.new_game_i),  .rise(ng_rise));

  assign p1_inc    = p1_score + SCORE_W'(1);
  assign p2_inc    = p2_score + SCORE_W'(1);
  // A new-game rise swallows any press in the same cycle.
  assign can_score = (state == ST_PLAY) && !ng_rise;
  assign p1_award  = can_score && p1_rise && !p2_rise && (p1_score != SAT);
  assign p2_award  = can_score && p2_rise && !p1_rise && (p2_score != SAT);
  assign p1_win    = p1_award && wins(p1_inc, p2_score, WIN_POINTS, WIN_MARGIN);
  assign p2_win    = p2_award && wins(p2_inc, p1_score, WIN_POINTS, WIN_MARGIN);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_PLAY;
      winner     <= WIN_NONE;
      lock_cnt   <= '0;
      p1_score   <= '0;
      p2_score   <= '0;
      point_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      winner     <= winner_nxt;
      lock_cnt   <= lock_cnt_nxt;
      p1_score   <= p1_nxt;
      p2_score   <= p2_nxt;
      point_q    <= point_nxt;
      conflict_q <= conflict_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (ng_rise) begin
      state_nxt = ST_PLAY;
    end else begin
      case (state)
        ST_PLAY: begin
          if (p1_win || p2_win)          state_nxt = ST_GAME_OVER;
          else if (p1_award || p2_award) state_nxt = ST_LOCKOUT;
        end
        ST_LOCKOUT: begin
          if (lock_cnt <= CNT_W'(1)) state_nxt = ST_PLAY;
        end
        ST_GAME_OVER: state_nxt = ST_GAME_OVER;
        default:      state_nxt = ST_PLAY;
      endcase
    end
  end

  always_comb begin
    p1_nxt       = p1_score;
    p2_nxt       = p2_score;
    winner_nxt   = winner;
    lock_cnt_nxt = lock_cnt;
    point_nxt    = 1'b0;
    conflict_nxt = 1'b0;
    if (ng_rise) begin
      p1_nxt       = '0;
      p2_nxt       = '0;
      winner_nxt   = WIN_NONE;
      lock_cnt_nxt = '0;
    end else begin
      case (state)
        ST_PLAY: begin
          conflict_nxt = p1_rise && p2_rise;
          if (p1_award) begin
            p1_nxt    = p1_inc;
            point_nxt = 1'b1;
            if (p1_win) winner_nxt   = WIN_P1;
            else        lock_cnt_nxt = LOCK_LOAD;
          end else if (p2_award) begin
            p2_nxt    = p2_inc;
            point_nxt = 1'b1;
            if (p2_win) winner_nxt   = WIN_P2;
            else        lock_cnt_nxt = LOCK_LOAD;
          end
        end
        ST_LOCKOUT: begin
          if (lock_cnt != '0) lock_cnt_nxt = lock_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.p1_score_o = p1_score;
  assign bus.p2_score_o = p2_score;
  assign bus.winner_o   = winner;
  assign bus.state_o    = state;
  assign bus.point_o    = point_q;
  assign bus.conflict_o = conflict_q;

endmodule

// File: tb/tb_scoreboard_match_sequencer.sv
// Directed and random checks of the scoreboard controller against a timestamp-based game model.
module tb_scoreboard_match_sequencer;
  import scoreboard_pkg::*;

  localparam int L    = 4;
  localparam int WP   = 11;
  localparam int WM   = 2;
  localparam int SMAX = 99;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scoreboard_match_sequencer_if bus();

  scoreboard_match_sequencer #(
    .WIN_POINTS(WP), .WIN_MARGIN(WM), .LOCKOUT_CYCLES(L), .SCORE_MAX(SMAX)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;
  int edge_n = 0;

  // Model: scores, winner (0 none / 1 P1 / 2 P2), and the first edge at which a press may score.
  int m_p1, m_p2, m_win, m_accept, m_point, m_conf;
  bit pb1, pb2, png;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
  endtask

  function automatic int exp_state();
    if (m_win != 0) return 2;
    return (edge_n + 1 < m_accept) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".p1"},       32'(bus.p1_score_o), 32'(m_p1));
    check({tag, ".p2"},       32'(bus.p2_score_o), 32'(m_p2));
    check({tag, ".winner"},   32'(bus.winner_o),   32'(m_win));
    check({tag, ".state"},    32'(bus.state_o),    32'(exp_state()));
    check({tag, ".point"},    32'(bus.point_o),    32'(m_point));
    check({tag, ".conflict"}, 32'(bus.conflict_o), 32'(m_conf));
  endtask

  task automatic model_step(input bit b1, input bit b2, input bit ng);
    bit r1, r2, rn;
    r1 = b1 && !pb1;
    r2 = b2 && !pb2;
    rn = ng && !png;
    pb1 = b1; pb2 = b2; png = ng;
    m_point = 0;
    m_conf  = 0;
    if (rn) begin
      m_p1 = 0; m_p2 = 0; m_win = 0; m_accept = 0;
    end else if (m_win == 0 && edge_n >= m_accept) begin
      if (r1 && r2) begin
        m_conf = 1;
      end else if (r1 && m_p1 < SMAX) begin
        m_p1++;
        m_point = 1;
        if (m_p1 >= WP && m_p1 >= m_p2 + WM) m_win = 1;
        else m_accept = edge_n + L + 1;
      end else if (r2 && m_p2 < SMAX) begin
        m_p2++;
        m_point = 1;
        if (m_p2 >= WP && m_p2 >= m_p1 + WM) m_win = 2;
        else m_accept = edge_n + L + 1;
      end
    end
  endtask

  task automatic cycle(input bit b1, input bit b2, input bit ng);
    bus.p1_button_i = b1;
    bus.p2_button_i = b2;
    bus.new_game_i  = ng;
    @(posedge clk);
    edge_n++;
    model_step(b1, b2, ng);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset(input bit p2_level);
    bus.p1_button_i = 1'b0;
    bus.p2_button_i = p2_level;
    bus.new_game_i  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    edge_n++;
    m_p1 = 0; m_p2 = 0; m_win = 0; m_accept = 0; m_point = 0; m_conf = 0;
    pb1 = 0; pb2 = 0; png = 0;
    #1;
    rst = 1'b0;
    bus.p2_button_i = 1'b0;
    check_all("reset");
  endtask

  task automatic press(input int who);
    cycle(who == 1, who == 2, 1'b0);
    repeat (L) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.p1_button_i = 1'b0;
    bus.p2_button_i = 1'b0;
    bus.new_game_i  = 1'b0;

    // Single press: score after one edge, four lockout cycles, back to PLAY.
    do_reset(1'b0);
    cycle(1, 0, 0);
    check("tp1_score", 32'(bus.p1_score_o), 32'd1);
    check("tp1_point", 32'(bus.point_o), 32'd1);
    check("tp1_lock",  32'(bus.state_o), 32'd1);
    for (int i = 0; i < L; i++) begin
      cycle(0, 0, 0);
      check("tp1_lock_len", 32'(bus.state_o), (i < L - 1) ? 32'd1 : 32'd0);
    end

    // Press during lockout is dropped; a fresh rise afterwards scores.
    do_reset(1'b0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("tp2_ignored", 32'(bus.p1_score_o), 32'd1);
    check("tp2_nopoint", 32'(bus.point_o), 32'd0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("tp2_second", 32'(bus.p1_score_o), 32'd2);
    repeat (L) cycle(0, 0, 0);

    // Simultaneous rise at 3:3.
    do_reset(1'b0);
    repeat (3) begin press(1); press(2); end
    cycle(1, 1, 0);
    check("tp3_conflict", 32'(bus.conflict_o), 32'd1);
    check("tp3_p1", 32'(bus.p1_score_o), 32'd3);
    check("tp3_p2", 32'(bus.p2_score_o), 32'd3);
    check("tp3_state", 32'(bus.state_o), 32'd0);
    cycle(0, 0, 0);
    check("tp3_pulse", 32'(bus.conflict_o), 32'd0);

    // Win by margin from 10:10, then frozen.
    do_reset(1'b0);
    repeat (10) begin press(1); press(2); end
    cycle(1, 0, 0);
    check("tp4_11_10_win", 32'(bus.winner_o), 32'd0);
    check("tp4_11_10_st",  32'(bus.state_o),  32'd1);
    repeat (L) cycle(0, 0, 0);
    cycle(1, 0, 0);
    check("tp4_winner", 32'(bus.winner_o), 32'd1);
    check("tp4_over",   32'(bus.state_o),  32'd2);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("tp4_frozen_p1", 32'(bus.p1_score_o), 32'd12);
    check("tp4_frozen_p2", 32'(bus.p2_score_o), 32'd10);

    // New game beats a simultaneous P2 rise.
    cycle(0, 1, 1);
    check("tp5_p1", 32'(bus.p1_score_o), 32'd0);
    check("tp5_p2", 32'(bus.p2_score_o), 32'd0);
    check("tp5_winner", 32'(bus.winner_o), 32'd0);
    check("tp5_state", 32'(bus.state_o), 32'd0);
    check("tp5_point", 32'(bus.point_o), 32'd0);
    cycle(0, 0, 0);

    // Reset mid-lockout discards everything.
    do_reset(1'b0);
    repeat (6) press(2);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    check("tp6_pre", 32'(bus.p2_score_o), 32'd7);
    do_reset(1'b1);
    check("tp6_rst_p2", 32'(bus.p2_score_o), 32'd0);
    check("tp6_rst_state", 32'(bus.state_o), 32'd0);
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    check("tp6_fresh", 32'(bus.p2_score_o), 32'd1);
    repeat (L) cycle(0, 0, 0);

    // Saturation at SCORE_MAX through a long deuce.
    do_reset(1'b0);
    repeat (SMAX - 1) begin press(1); press(2); end
    press(1);
    check("tp7_99_98", 32'(bus.p1_score_o), 32'd99);
    cycle(1, 0, 0);
    check("tp7_sat_point", 32'(bus.point_o), 32'd0);
    check("tp7_sat_state", 32'(bus.state_o), 32'd0);
    check("tp7_sat_score", 32'(bus.p1_score_o), 32'd99);
    cycle(0, 0, 0);
    press(2);
    check("tp7_99_99", 32'(bus.p2_score_o), 32'd99);
    check("tp7_nowin", 32'(bus.winner_o), 32'd0);

    // Random play with occasional new games.
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
